// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes and forward-select codes.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_OR  = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_MO  = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux4.sv
// Operand forwarding select in ID: register file, EXE result, MEM result or memory load data.
module fwd_mux4
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::XLEN
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] rf_val,
  input  logic [WIDTH-1:0] exe_val,
  input  logic [WIDTH-1:0] mem_val,
  input  logic [WIDTH-1:0] mo_val,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = rf_val;
    case (sel)
      FWD_RF:  y = rf_val;
      FWD_EXE: y = exe_val;
      FWD_MEM: y = mem_val;
      default: y = mo_val;
    endcase
  end

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register: forwards operands, latches decoded control and feeds the EXE ALU.
module id_exe_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RW   = cpu_pkg::RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dwreg,
  input  logic            dm2reg,
  input  logic            dwmem,
  input  logic [2:0]      daluc,
  input  logic            daluimm,
  input  logic            dshift,
  input  logic [RW-1:0]   drn,
  input  logic [XLEN-1:0] dimm,
  input  logic [XLEN-1:0] qa,
  input  logic [XLEN-1:0] qb,
  input  logic [1:0]      fwda,
  input  logic [1:0]      fwdb,
  input  logic [XLEN-1:0] exe_res,
  input  logic [XLEN-1:0] mem_res,
  input  logic [XLEN-1:0] mem_mo,
  input  logic            stall,
  input  logic            flush,
  input  logic            hold,
  output logic            ewreg,
  output logic            em2reg,
  output logic            ewmem,
  output logic [RW-1:0]   ern,
  output logic [XLEN-1:0] eb,
  output logic            evalid,
  output logic [XLEN-1:0] alua,
  output logic [XLEN-1:0] alub,
  output logic [2:0]      ealuc
);

  typedef struct packed {
    logic            wreg;
    logic            m2reg;
    logic            wmem;
    logic [2:0]      aluc;
    logic            aluimm;
    logic            shift;
    logic [RW-1:0]   rn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic            valid;
  } ex_state_t;

  logic [XLEN-1:0] da;
  logic [XLEN-1:0] db;
  ex_state_t       ex_d;
  ex_state_t       ex_q;

  fwd_mux4 #(.WIDTH(XLEN)) u_fwd_a (
    .sel(fwda), .rf_val(qa), .exe_val(exe_res), .mem_val(mem_res), .mo_val(mem_mo), .y(da)
  );

  fwd_mux4 #(.WIDTH(XLEN)) u_fwd_b (
    .sel(fwdb), .rf_val(qb), .exe_val(exe_res), .mem_val(mem_res), .mo_val(mem_mo), .y(db)
  );

  // Flush outranks hold so a squashed instruction can never survive a freeze.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = '0;
    end else begin
      ex_d.wreg   = dwreg;
      ex_d.m2reg  = dm2reg;
      ex_d.wmem   = dwmem;
      ex_d.aluc   = daluc;
      ex_d.aluimm = daluimm;
      ex_d.shift  = dshift;
      ex_d.rn     = drn;
      ex_d.a      = da;
      ex_d.b      = db;
      ex_d.imm    = dimm;
      ex_d.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ewreg  = ex_q.wreg;
  assign em2reg = ex_q.m2reg;
  assign ewmem  = ex_q.wmem;
  assign ern    = ex_q.rn;
  assign eb     = ex_q.b;
  assign evalid = ex_q.valid;
  assign ealuc  = ex_q.aluc;

  // Shift instructions take the shift amount from immediate bits [10:6].
  assign alua = ex_q.shift ? {{(XLEN-5){1'b0}}, ex_q.imm[10:6]} : ex_q.a;
  assign alub = ex_q.aluimm ? ex_q.imm : ex_q.b;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed and randomized bench for id_exe_pipe against a cycle-level behavioural model.
module tb_id_exe_pipe;
  import cpu_pkg::*;

  localparam int W = 108;

  logic        clk;
  logic        rst;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift;
  logic [2:0]  daluc;
  logic [4:0]  drn;
  logic [31:0] dimm, qa, qb, exe_res, mem_res, mem_mo;
  logic [1:0]  fwda, fwdb;
  logic        stall, flush, hold;
  logic        ewreg, em2reg, ewmem, evalid;
  logic [4:0]  ern;
  logic [31:0] eb, alua, alub;
  logic [2:0]  ealuc;

  id_exe_pipe dut (
    .clk(clk), .rst(rst), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc),
    .daluimm(daluimm), .dshift(dshift), .drn(drn), .dimm(dimm), .qa(qa), .qb(qb),
    .fwda(fwda), .fwdb(fwdb), .exe_res(exe_res), .mem_res(mem_res), .mem_mo(mem_mo),
    .stall(stall), .flush(flush), .hold(hold), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ern(ern), .eb(eb), .evalid(evalid), .alua(alua), .alub(alub),
    .ealuc(ealuc)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction occupying the EXE slot
  logic        m_wreg, m_m2reg, m_wmem, m_aluimm, m_shift, m_valid;
  logic [2:0]  m_aluc;
  logic [4:0]  m_rn;
  logic [31:0] m_a, m_b, m_imm;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    {m_wreg, m_m2reg, m_wmem, m_aluimm, m_shift, m_valid} = '0;
    m_aluc = '0; m_rn = '0; m_a = '0; m_b = '0; m_imm = '0;
  endtask

  // What the EXE slot holds after the coming edge, given the current inputs.
  task automatic model_edge();
    logic [31:0] src[4];
    src[0] = qa; src[1] = exe_res; src[2] = mem_res; src[3] = mem_mo;
    if (rst || flush || (!hold && stall)) begin
      model_clear();
    end else if (!hold) begin
      m_wreg = dwreg; m_m2reg = dm2reg; m_wmem = dwmem; m_aluc = daluc;
      m_aluimm = daluimm; m_shift = dshift; m_rn = drn; m_imm = dimm;
      m_a = src[fwda];
      src[0] = qb;
      m_b = src[fwdb];
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [31:0] a_op, b_op;
    a_op = m_shift ? ((m_imm >> 6) & 32'h1F) : m_a;
    b_op = m_aluimm ? m_imm : m_b;
    return {m_wreg, m_m2reg, m_wmem, m_rn, m_b, m_valid, a_op, b_op, m_aluc};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {ewreg, em2reg, ewmem, ern, eb, evalid, alua, alub, ealuc};
  endfunction

  // Drivers
  task automatic rand_id();
    dwreg   = 1'($urandom_range(0, 1));
    dm2reg  = 1'($urandom_range(0, 1));
    dwmem   = 1'($urandom_range(0, 1));
    daluimm = 1'($urandom_range(0, 1));
    dshift  = 1'($urandom_range(0, 1));
    daluc   = 3'($urandom_range(0, 6));
    drn     = 5'($urandom_range(0, 31));
    fwda    = 2'($urandom_range(0, 3));
    fwdb    = 2'($urandom_range(0, 3));
    dimm    = $urandom; qa = $urandom; qb = $urandom;
    exe_res = $urandom; mem_res = $urandom; mem_mo = $urandom;
  endtask

  task automatic ctl(input logic r, input logic s, input logic f, input logic h);
    rst = r; stall = s; flush = f; hold = h;
  endtask

  task automatic step(input string tag);
    logic [W-1:0] exp;
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, dut_out(), exp);
  endtask

  logic [W-1:0] held;
  logic [31:0]  fwd_exp[4];

  initial begin
    model_clear();
    rand_id();
    ctl(1, 0, 0, 0);

    // Reset with random ID inputs
    step("reset1");
    rand_id();
    step("reset2");
    check("reset_evalid", W'(evalid), W'(0));
    check("reset_alua", W'(alua), W'(0));
    check("reset_alub", W'(alub), W'(0));

    // First load after reset
    rand_id();
    ctl(0, 0, 0, 0);
    daluc = ALU_SUB; drn = 5'd7;
    step("first_load");
    check("first_ealuc", W'(ealuc), W'(3'b110));
    check("first_ern", W'(ern), W'(7));
    check("first_evalid", W'(evalid), W'(1));

    // Forwarding sweep on operand A
    fwd_exp[0] = 32'h1; fwd_exp[1] = 32'h10; fwd_exp[2] = 32'h20; fwd_exp[3] = 32'h30;
    for (int f = 0; f < 4; f++) begin
      rand_id();
      qa = 32'h1; exe_res = 32'h10; mem_res = 32'h20; mem_mo = 32'h30;
      dshift = 1'b0; fwda = 2'(f);
      step("fwd_step");
      check("fwd_alua", W'(alua), W'(fwd_exp[f]));
    end

    // Immediate and shift amount
    rand_id();
    dshift = 1'b1; dimm = 32'h0000_02C0; daluimm = 1'b1; daluc = ALU_SLL;
    step("imm_step");
    check("imm_alua", W'(alua), W'(32'h0000_000B));
    check("imm_alub", W'(alub), W'(32'h0000_02C0));
    check("imm_ealuc", W'(ealuc), W'(3'b101));

    // Load-use bubble
    rand_id();
    dwreg = 1'b1; dwmem = 1'b0; daluc = ALU_ADD;
    step("stall_pre");
    check("stall_pre_ewreg", W'(ewreg), W'(1));
    rand_id();
    ctl(0, 1, 0, 0);
    step("stall_bubble");
    check("stall_ewreg", W'(ewreg), W'(0));
    check("stall_ewmem", W'(ewmem), W'(0));
    check("stall_evalid", W'(evalid), W'(0));
    check("stall_ealuc", W'(ealuc), W'(0));
    rand_id();
    ctl(0, 0, 0, 0);
    step("stall_resume");
    check("resume_evalid", W'(evalid), W'(1));

    // Hold for three cycles, then flush overrides hold
    held = model_out();
    for (int i = 0; i < 3; i++) begin
      rand_id();
      ctl(0, 1'($urandom_range(0, 1)), 0, 1);
      step("hold_step");
      check("hold_frozen", dut_out(), held);
    end
    rand_id();
    ctl(0, 0, 1, 1);
    step("flush_hold");
    check("flush_hold_evalid", W'(evalid), W'(0));
    check("flush_hold_ewreg", W'(ewreg), W'(0));

    // Store path through MEM forwarding on operand B
    rand_id();
    ctl(0, 0, 0, 0);
    dwmem = 1'b1; fwdb = FWD_MEM; mem_res = 32'hDEAD_BEEF; daluimm = 1'b1;
    step("store_step");
    check("store_eb", W'(eb), W'(32'hDEAD_BEEF));
    check("store_alub", W'(alub), W'(dut.ex_q.imm));
    check("store_ewmem", W'(ewmem), W'(1));

    // Randomized traffic with sporadic control events
    for (int i = 0; i < 400; i++) begin
      rand_id();
      ctl($urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      step("random");
    end

    // Long hold keeps state
    rand_id();
    ctl(0, 0, 0, 0);
    step("long_hold_load");
    held = model_out();
    for (int i = 0; i < 50; i++) begin
      rand_id();
      ctl(0, 1'($urandom_range(0, 1)), 0, 1);
      step("long_hold");
    end
    check("long_hold_frozen", dut_out(), held);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe.md
Name: id_exe_pipe

Overview:
- ID/EXE pipeline register of the 5-stage pipeline; sits directly upstream of the EXE-stage ALU.
- Selects forwarded operands in ID, latches them with decoded control each cycle, and drives the ALU operand and opcode inputs (alua, alub, ealuc) combinationally from the registered state.
- Implements load-use bubble insertion, branch flush and whole-stage hold.

Parameters:
- XLEN, 32, datapath width.
- RW, 5, register-number width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- dwreg  in  1  ID: instruction writes register file.
- dm2reg  in  1  ID: result comes from memory.
- dwmem  in  1  ID: store.
- daluc  in  3  ID: ALU op code (000 add, 001 and, 010 or, 011 xor, 100 srl, 101 sll, 110 sub).
- daluimm  in  1  ID: ALU B operand is the immediate.
- dshift  in  1  ID: ALU A operand is the shamt.
- drn  in  RW  ID: destination register.
- dimm  in  XLEN  ID: sign/zero-extended immediate.
- qa, qb  in  XLEN  ID: register-file read data.
- fwda, fwdb  in  2  ID forward select: 00 qa/qb, 01 exe_res, 10 mem_res, 11 mem_mo.
- exe_res, mem_res, mem_mo  in  XLEN  forwarded results.
- stall  in  1  load-use stall; inserts a bubble.
- flush  in  1  squash the instruction in ID.
- hold  in  1  freeze this stage.
- ewreg, em2reg, ewmem  out  1  registered control.
- ern  out  RW  registered destination.
- eb  out  XLEN  registered B operand, also used as store data.
- evalid  out  1  the EXE slot holds a real instruction.
- alua  out  XLEN  ALU A operand.
- alub  out  XLEN  ALU B operand.
- ealuc  out  3  ALU op code.

Behaviour:
- Single clock; all state updates on the rising edge of clk. Reset is synchronous, active-high.
- Registered state: ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ern, ea, eb, eimm, evalid.
- Reset value of every register is 0, so after reset alua=0, alub=0, ealuc=000 and evalid=0.
- Operand forwarding (combinational, ID side):
  - da = mux(fwda: qa, exe_res, mem_res, mem_mo).
  - db = mux(fwdb: qb, exe_res, mem_res, mem_mo).
- Update priority per edge: rst > flush > hold > stall > load.
  - rst: all registers cleared.
  - flush: bubble. ewreg, em2reg, ewmem, evalid, ealuimm, eshift are cleared; ealuc=000; ern=0; ea, eb, eimm are don't-care but are cleared.
  - hold (and no flush): all registers keep their value, including evalid.
  - stall (and no hold, no flush): bubble, identical to flush.
  - load: all registers take their d* values (ea=da, eb=db), and evalid=1.
- flush together with hold: flush wins, so the squashed instruction never executes.
- Combinational outputs from registered state:
  - alua = eshift ? {zeros, eimm[10:6]} : ea.
  - alub = ealuimm ? eimm : eb.
- Latency: ID inputs appear on the outputs one cycle after the load edge. Forwarded values are sampled at the same edge.
- A bubble must be architecturally inert: ewreg=0 and ewmem=0. The ALU still computes 0+0.
- No internal counters wrap. A hold of arbitrary length must be supported with no loss of state.

Decomposition:
- Shared package cpu_pkg:
  - ALU op constants ALU_ADD=000, ALU_AND=001, ALU_OR=010, ALU_XOR=011, ALU_SRL=100, ALU_SLL=101, ALU_SUB=110.
  - FWD_RF=00, FWD_EXE=01, FWD_MEM=10, FWD_MO=11.
  - XLEN and RW.
- One sub-module, fwd_mux4 (XLEN-wide 4:1 mux), instantiated twice for da and db.

Test Plan:
- Reset: assert rst for 2 cycles with random ID inputs -> all outputs 0, evalid=0. Deassert rst with daluc=110, drn=7 -> next cycle ealuc=110, ern=7, evalid=1.
- Forwarding: qa=1, exe_res=0x10, mem_res=0x20, mem_mo=0x30; sweep fwda 00..11 with dshift=0 -> alua = 1, 0x10, 0x20, 0x30 on successive cycles.
- Immediate/shift: dshift=1, dimm=0x000002C0, daluimm=1, daluc=101 -> alua=0x0000000B, alub=0x000002C0, ealuc=101.
- Stall: load a valid add with ewreg=1, then raise stall for 1 cycle -> next cycle ewreg=0, ewmem=0, evalid=0, ealuc=000. The following load restores normal flow.
- Hold: hold=1 for 3 cycles while ID inputs change -> outputs unchanged across all 3 cycles. Then flush=1 together with hold=1 -> bubble (evalid=0).
- Store path: dwmem=1, fwdb=10, mem_res=0xDEADBEEF, daluimm=1 -> eb=0xDEADBEEF, alub=eimm, ewmem=1.
